// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage port with a posted store buffer and a variable-latency bus master.
// Optional feature macro MEM_ADDR_EXC_EN: misaligned accesses raise AdEL/AdES instead of being force-aligned.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_sign_ext,
  input  logic [1:0]                req_size,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      req_flush,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic [1:0]                resp_exc,
  output logic [ADDR_WIDTH-1:0]     resp_badvaddr,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [DATA_WIDTH/8-1:0]   bus_wstrb,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH-1:0]     bus_wdata,
  input  logic                      bus_ack,
  input  logic [DATA_WIDTH-1:0]     bus_rdata,
  output logic                      sb_empty
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LREQ, LKILL} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] sb_addr [SB_DEPTH];
  logic [LANES-1:0]      sb_strb [SB_DEPTH];
  logic [DATA_WIDTH-1:0] sb_data [SB_DEPTH];
  logic [PTR_W-1:0]      sb_head, sb_tail;
  logic [CNT_W-1:0]      sb_count;

  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [OFF_W-1:0]      ld_off;
  logic [1:0]            ld_size;
  logic                  ld_sext;

  logic                  sb_full, rd_active, wr_active, sb_pop, sb_push, accept, exc_hit;
  logic [1:0]            eff_size;
  logic [ADDR_WIDTH-1:0] low_mask, eff_addr, lane_addr;
  logic [OFF_W-1:0]      eff_off;
  logic [7:0]            strb_base;
  logic [LANES-1:0]      eff_strb;
  logic [DATA_WIDTH-1:0] eff_wdata;

  // Reads own the bus while in flight; otherwise the buffer head drives it.
  assign sb_full   = (sb_count == CNT_W'(SB_DEPTH));
  assign rd_active = (state == LREQ) || (state == LKILL);
  assign wr_active = !rd_active && (sb_count != '0);
  assign bus_req   = rd_active || wr_active;
  assign bus_we    = wr_active;
  assign bus_addr  = rd_active ? ld_addr : (wr_active ? sb_addr[sb_head] : '0);
  assign bus_wstrb = wr_active ? sb_strb[sb_head] : '0;
  assign bus_wdata = wr_active ? sb_data[sb_head] : '0;
  assign sb_pop    = wr_active && bus_ack;
  assign sb_empty  = (sb_count == '0);
  assign req_ready = (state == IDLE) && !sb_full;
  assign accept    = req_valid && req_ready && !req_flush;
  assign sb_push   = accept && req_write && !exc_hit;

  always_comb begin
    eff_size = req_size;
    if (DATA_WIDTH == 32 && req_size == 2'd3) eff_size = 2'd2;
    unique case (eff_size)
      2'd0:    begin low_mask = '0;              strb_base = 8'h01; end
      2'd1:    begin low_mask = ADDR_WIDTH'(1);  strb_base = 8'h03; end
      2'd2:    begin low_mask = ADDR_WIDTH'(3);  strb_base = 8'h0F; end
      default: begin low_mask = ADDR_WIDTH'(7);  strb_base = 8'hFF; end
    endcase
    eff_addr  = req_addr & ~low_mask;
    eff_off   = eff_addr[OFF_W-1:0];
    lane_addr = {eff_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    eff_strb  = LANES'(strb_base) << eff_off;
    eff_wdata = req_wdata << {eff_off, 3'b000};
  end

`ifdef MEM_ADDR_EXC_EN
  assign exc_hit = (DATA_WIDTH == 32 && req_size == 2'd3) || ((req_addr & low_mask) != '0);
`else
  assign exc_hit = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [1:0] sz, input logic sx);
    logic [DATA_WIDTH-1:0] r;
    logic                  sgn;
    int                    nb;
    nb = 8 << sz;
    if (nb > DATA_WIDTH) nb = DATA_WIDTH;
    sgn = sx & d[nb-1];
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = (i < nb) ? d[i] : sgn;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (sb_push) begin
      sb_addr[sb_tail] <= lane_addr;
      sb_strb[sb_tail] <= eff_strb;
      sb_data[sb_tail] <= eff_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sb_head       <= '0;
      sb_tail       <= '0;
      sb_count      <= '0;
      ld_addr       <= '0;
      ld_off        <= '0;
      ld_size       <= '0;
      ld_sext       <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= '0;
      resp_badvaddr <= '0;
    end else begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= '0;
      resp_badvaddr <= '0;
      if (sb_push) sb_tail <= sb_tail + PTR_W'(1);
      if (sb_pop)  sb_head <= sb_head + PTR_W'(1);
      sb_count <= sb_count + CNT_W'(sb_push) - CNT_W'(sb_pop);

      unique case (state)
        IDLE: begin
          if (accept) begin
            if (exc_hit) begin
              resp_valid    <= 1'b1;
              resp_exc      <= {req_write, !req_write};
              resp_badvaddr <= req_addr;
            end else if (req_write) begin
              resp_valid <= 1'b1;
            end else begin
              ld_addr <= lane_addr;
              ld_off  <= eff_off;
              ld_size <= eff_size;
              ld_sext <= req_sign_ext;
              // A head store acked this very cycle already counts as drained.
              state   <= (sb_count == CNT_W'(sb_pop)) ? LREQ : DRAIN;
            end
          end
        end
        DRAIN: begin
          if (req_flush) state <= IDLE;
          else if (sb_count == '0 || (sb_count == CNT_W'(1) && sb_pop)) state <= LREQ;
        end
        LREQ: begin
          if (bus_ack) begin
            state <= IDLE;
            if (!req_flush) begin
              resp_valid <= 1'b1;
              resp_rdata <= extend(bus_rdata >> {ld_off, 3'b000}, ld_size, ld_sext);
            end
          end else if (req_flush) begin
            state <= LKILL;
          end
        end
        LKILL: begin
          if (bus_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, multi-cycle memory access unit for the MEM stage. It replaces the single-cycle combinational RAM port with a handshaked pipeline interface, a posted store buffer and a variable-latency bus master. Load data is aligned and extended inside the unit. It sits between the EX/MEM pipeline register and the data bus / cache port, and stalls the pipeline through `req_ready`.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: bus data width, 32 or 64; `LANES = DATA_WIDTH/8`.
- `SB_DEPTH`, default 4: store buffer entries, power of two, at least 2.
- `clk` in, 1: sole clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: request accepted this cycle when both `req_valid` and `req_ready` are high.
- `req_write` in, 1: 1 means store, 0 means load.
- `req_sign_ext` in, 1: load sign-extends.
- `req_size` in, 2: 0 byte, 1 half, 2 word, 3 doubleword (3 only legal when `DATA_WIDTH`=64).
- `req_addr` in, `ADDR_WIDTH`: byte address.
- `req_wdata` in, `DATA_WIDTH`: store data, right-justified.
- `req_flush` in, 1: kills the pending load and any request presented this cycle.
- `resp_valid` out, 1: one-cycle completion pulse.
- `resp_rdata` out, `DATA_WIDTH`: aligned, extended load data; 0 for stores.
- `resp_exc` out, 2: 00 none, 01 AdEL, 10 AdES.
- `resp_badvaddr` out, `ADDR_WIDTH`: faulting address when `resp_exc` is nonzero, else 0.
- `bus_req` out, 1: bus transaction request.
- `bus_we` out, 1: write transaction.
- `bus_wstrb` out, `LANES`: byte enables.
- `bus_addr` out, `ADDR_WIDTH`: lane-aligned address (low log2(`LANES`) bits are zero).
- `bus_wdata` out, `DATA_WIDTH`: lane-shifted store data.
- `bus_ack` in, 1: the transaction completes at the edge where `bus_req` and `bus_ack` are both high.
- `bus_rdata` in, `DATA_WIDTH`: valid in the `bus_ack` cycle of a read.
- `sb_empty` out, 1: store buffer empty and no write in flight.

## Operation
- FSM states:
  - IDLE.
  - DRAIN: the load waits for the store buffer to empty.
  - LREQ: read is on the bus.
  - LKILL: flushed read is awaiting its ack.
- Stores:
  - Accepted when the buffer is not full, the state is IDLE and `req_flush` is low.
  - On acceptance, the entry (addr, wstrb, shifted data) is pushed and `resp_valid` pulses the next cycle.
  - Store completion is posted, not bus completion.
- Store buffer:
  - FIFO with wrapping head/tail pointers and a count.
  - Head is presented on the bus whenever the buffer is non-empty and no read is in flight.
  - Pops on `bus_ack`.
  - Push and pop in the same cycle leave the count unchanged; push while full is impossible because `req_ready` is low.
- Loads:
  - Accepted only in IDLE; `req_ready` is low in every other state.
  - From IDLE the FSM goes to DRAIN if the buffer is non-empty, else to LREQ.
  - DRAIN goes to LREQ in the cycle after the last store is acked.
  - LREQ goes to IDLE on `bus_ack`. The data is registered: `resp_rdata` = (`bus_rdata` >> 8·offset), truncated to the size and sign/zero-extended per `req_sign_ext`.
  - No store forwarding: drain before read guarantees ordering.
- Byte lanes:
  - offset = `addr[log2(LANES)-1:0]`.
  - `bus_wstrb` = ((1<<(1<<size))−1) << offset.
  - `bus_wdata` = `req_wdata` << 8·offset.
- Flush:
  - In DRAIN, goes to IDLE with no response.
  - In LREQ, goes to LKILL; the bus request is held until ack, the data is discarded, and the FSM then returns to IDLE with no `resp_valid`.
  - Buffered stores are never flushed.
- Simultaneous events: `req_flush` together with `req_valid` means the request is not accepted.
- Reset, including mid-transaction:
  - State returns to IDLE and the buffer empties.
  - All outputs go to 0, except `req_ready`=1 and `sb_empty`=1.
  - The bus slave must tolerate an abandoned request.

## Timing
- Store accepted at cycle N: `resp_valid` at N+1; its `bus_req` at N+1 at the earliest (buffer empty).
- Back-to-back stores sustain 1/cycle until full; when full, `req_ready` stays low until the pop edge and rises the cycle after the pop.
- Load with an empty buffer, accepted at N: `bus_req` at N+1; with ack at cycle A, `resp_valid` at A+1.
- Bus fields are stable from `bus_req` assertion through the ack edge; `bus_req` may reassert the cycle after an ack.

## Configuration
- `MEM_ADDR_EXC_EN` defined:
  - A misaligned request (address not a multiple of 1<<size), or size 3 with 32-bit data, is accepted in IDLE.
  - It causes no bus access and no buffer push.
  - `resp_valid` pulses at N+1 with `resp_exc` = AdEL (load) or AdES (store) and `resp_badvaddr` = `req_addr`.
- `MEM_ADDR_EXC_EN` undefined:
  - Low address bits are cleared to natural alignment.
  - Size 3 at 32-bit data is treated as a word access.
  - `resp_exc`/`resp_badvaddr` are tied to 0.

## Test plan
- SB_DEPTH=4, bus_ack held low, 5 consecutive word stores -> 4 accepted with `resp_valid` pulses, `req_ready` low on the 5th; first ack -> 5th accepted the cycle after.
- `sb` to 0x1003 with data 0xAB -> `bus_wstrb`=1000, `bus_wdata`=0xAB000000, `bus_addr`=0x1000.
- Store then `lh` sign-ext at 0x1002 (rdata 0x8001xxxx) -> read issued only after store ack; `resp_rdata`=0xFFFF8001 one cycle after read ack.
- Load in LREQ with `req_flush` at ack-3 -> bus_req held to ack, no `resp_valid`, `req_ready` high after ack.
- `lw` at 0x2002 with macro -> no `bus_req`, `resp_exc`=01, `resp_badvaddr`=0x2002; without macro -> read at 0x2000.
- `rst` pulsed with 3 stores buffered and a write in flight -> next cycle `bus_req`=0, `sb_empty`=1, `req_ready`=1.
